// File: rtl/quet_phim_4x4_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Imported by the scanner top and its testbench.
package quet_phim_4x4_pkg;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    DEB_P = 2'd1,
    HELD  = 2'd2,
    DEB_R = 2'd3
  } state_e;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'b1111;

  function automatic logic is_single(input logic [3:0] p);
    return $countones(~p) == 1;
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      ~p[0]:   idx = 2'd0;
      ~p[1]:   idx = 2'd1;
      ~p[2]:   idx = 2'd2;
      ~p[3]:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/quet_phim_4x4_if.sv
// Keypad-side bundle: tick, column sense, row drive and key outputs.
// master = scanner, slave = keypad/consumer side.
interface quet_phim_4x4_if;
  logic       ena1khz;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  ena1khz, col,
    output row, key_code, key_valid, key_held
  );

  modport slave (
    output ena1khz, col,
    input  row, key_code, key_valid, key_held
  );
endinterface

// File: rtl/quet_phim_4x4_dong_bo_2ff.sv
// 4-bit two-flop synchronizer, resets to all ones (idle columns).
// Used to bring the asynchronous column lines into the ckht domain.
module dong_bo_2ff (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta_d, meta_q;
  logic [3:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/quet_phim_4x4.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Rows rotate on each idle tick; a detected key freezes the row.
module quet_phim_4x4
  import quet_phim_4x4_pkg::*;
#(
  parameter int DB_MS = 20
) (
  input  logic              ckht,
  input  logic              rst,
  quet_phim_4x4_if.master   kp
);
  localparam int CW = $clog2(DB_MS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_MS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [3:0]    col_s;
  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q, cnt_inc;
  logic [1:0]    row_idx_d, row_idx_q;
  logic [3:0]    row_d, row_q;
  logic [3:0]    pat_d, pat_q;
  logic [3:0]    code_d, code_q;
  logic          valid_d, valid_q;
  logic          held_d, held_q;

  dong_bo_2ff u_sync (
    .clk (ckht),
    .rst (rst),
    .d   (kp.col),
    .q   (col_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
    pat_d     = pat_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    if (kp.ena1khz) begin
      unique case (state_q)
        SCAN: begin
          if (is_single(col_s)) begin
            pat_d = col_s;
            cnt_d = CNT_ONE;
            if (DB_MS == 1) begin
              code_d  = {row_idx_q, col_idx(col_s)};
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              state_d = DEB_P;
            end
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        DEB_P: begin
          if (col_s == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              code_d  = {row_idx_q, col_idx(pat_q)};
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end
          end else begin
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (col_s == COL_IDLE) begin
            cnt_d = CNT_ONE;
            if (DB_MS == 1) begin
              held_d    = 1'b0;
              row_idx_d = row_idx_q + 2'd1;
              cnt_d     = '0;
              state_d   = SCAN;
            end else begin
              state_d = DEB_R;
            end
          end
        end
        DEB_R: begin
          if (col_s == COL_IDLE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              held_d    = 1'b0;
              row_idx_d = row_idx_q + 2'd1;
              cnt_d     = '0;
              state_d   = SCAN;
            end
          end else begin
            cnt_d   = '0;
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
    row_d = ~(4'b0001 << row_idx_d);
  end

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      row_idx_q <= 2'd0;
      row_q     <= ROW_RESET;
      pat_q     <= COL_IDLE;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
      pat_q     <= pat_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign kp.row       = row_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
endmodule

// File: tb/tb_quet_phim_4x4.sv
// Directed bench for quet_phim_4x4 (DB_MS=4) with a key_valid scoreboard.
// Expected key codes are queued at stimulus time and popped by a monitor.
module tb_quet_phim_4x4;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [3:0] sb[$];

  quet_phim_4x4_if kp ();

  quet_phim_4x4 #(.DB_MS(4)) dut (
    .ckht (clk),
    .rst  (rst),
    .kp   (kp.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic step(input logic [3:0] c, input bit exp_v,
                      input logic [3:0] code);
    kp.col = c;
    repeat (3) @(negedge clk);
    if (exp_v) sb.push_back(code);
    kp.ena1khz = 1'b1;
    @(negedge clk);
    kp.ena1khz = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && kp.key_valid === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: got code %h expected no pulse",
                 kp.key_code);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        if (kp.key_code === e) n_pass++;
        else $display("FAIL key_code: got %h expected %h", kp.key_code, e);
      end
    end
  end

  initial begin
    logic [3:0] exp_rows[5];
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    kp.col = 4'b1111;
    kp.ena1khz = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_row", kp.row, 4'b1110);
    chk("rst_code", kp.key_code, 4'h0);
    chk("rst_valid", {3'b0, kp.key_valid}, 4'h0);
    chk("rst_held", {3'b0, kp.key_held}, 4'h0);

    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 4'h0);
      chk("idle_row", kp.row, exp_rows[i]);
    end
    step(4'b1111, 1'b0, 4'h0);
    chk("row2", kp.row, 4'b1011);

    for (int i = 0; i < 3; i++) begin
      step(4'b1101, 1'b0, 4'h0);
      chk("deb_p_held", {3'b0, kp.key_held}, 4'h0);
      chk("deb_p_row", kp.row, 4'b1011);
    end
    step(4'b1101, 1'b1, 4'h9);
    chk("press_held", {3'b0, kp.key_held}, 4'h1);
    chk("press_code", kp.key_code, 4'h9);
    chk("press_row", kp.row, 4'b1011);

    step(4'b1111, 1'b0, 4'h0);
    step(4'b1111, 1'b0, 4'h0);
    step(4'b1101, 1'b0, 4'h0);
    chk("rel_bounce_held", {3'b0, kp.key_held}, 4'h1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 4'h0);
      chk("rel_held", {3'b0, kp.key_held}, 4'h1);
      chk("rel_row", kp.row, 4'b1011);
    end
    step(4'b1111, 1'b0, 4'h0);
    chk("released", {3'b0, kp.key_held}, 4'h0);
    chk("rel_adv_row", kp.row, 4'b0111);
    chk("code_hold", kp.key_code, 4'h9);

    step(4'b1110, 1'b0, 4'h0);
    step(4'b1111, 1'b0, 4'h0);
    chk("bounce_row", kp.row, 4'b0111);
    for (int i = 0; i < 3; i++) begin
      step(4'b1110, 1'b0, 4'h0);
      chk("bounce_held", {3'b0, kp.key_held}, 4'h0);
    end
    step(4'b1110, 1'b1, 4'hC);
    chk("bounce_press", {3'b0, kp.key_held}, 4'h1);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 4'h0);
    chk("bounce_rel_row", kp.row, 4'b1110);

    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    for (int i = 0; i < 4; i++) begin
      step(4'b1001, 1'b0, 4'h0);
      chk("multi_row", kp.row, exp_rows[i]);
    end

    for (int i = 0; i < 3; i++) step(4'b0111, 1'b0, 4'h0);
    step(4'b0111, 1'b1, 4'h3);
    chk("row0_held", {3'b0, kp.key_held}, 4'h1);
    chk("row0_code", kp.key_code, 4'h3);

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_row", kp.row, 4'b1110);
    chk("arst_code", kp.key_code, 4'h0);
    chk("arst_valid", {3'b0, kp.key_valid}, 4'h0);
    chk("arst_held", {3'b0, kp.key_held}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 1'b0, 4'h0);
    chk("post_rst_row", kp.row, 4'b1101);

    repeat (4) @(negedge clk);
    chk("sb_empty", 4'(sb.size()), 4'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
